// File: rtl/clk_period_meter_if.sv
// Signal bundle between a square-wave source and clk_period_meter.
// With CLK_PERIOD_MINMAX_EN defined the bundle also carries hp_min/hp_max.
interface clk_period_meter_if #(
  parameter int unsigned CNT_W = 16
);
  logic             sig_in;
  logic [CNT_W-1:0] half_period;
  logic [CNT_W-1:0] n_est;
  logic             meas_valid;
  logic             locked;
  logic             timeout;
`ifdef CLK_PERIOD_MINMAX_EN
  logic [CNT_W-1:0] hp_min;
  logic [CNT_W-1:0] hp_max;

  modport master (
    output sig_in,
    input  half_period, n_est, meas_valid, locked, timeout, hp_min, hp_max
  );
  modport slave (
    input  sig_in,
    output half_period, n_est, meas_valid, locked, timeout, hp_min, hp_max
  );
`else
  modport master (
    output sig_in,
    input  half_period, n_est, meas_valid, locked, timeout
  );
  modport slave (
    input  sig_in,
    output half_period, n_est, meas_valid, locked, timeout
  );
`endif
endinterface

// File: rtl/clk_period_meter.sv
// Measures the half-period of an asynchronous square wave, reports the divider N, lock and LOS.
// Optional CLK_PERIOD_MINMAX_EN adds running min/max half-period outputs.
module clk_period_meter #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TOL        = 0,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic              clk,
  input  logic              reset,
  clk_period_meter_if.slave mon_io
);

  localparam int unsigned MatchW = $clog2(LOCK_COUNT);
  localparam logic [MatchW-1:0] MatchMax = MatchW'(LOCK_COUNT - 1);
  localparam logic [CNT_W-1:0]  CntLast  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]    TolW     = (CNT_W + 1)'(TOL);

  typedef enum logic [1:0] {StIdle, StArmed, StTrack} state_e;

  state_e            state_q, state_d;
  logic              s1_q, s2_q, d_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  half_period_q, half_period_d;
  logic [CNT_W-1:0]  n_est_q, n_est_d;
  logic              meas_valid_q, meas_valid_d;
  logic              locked_q, locked_d;
  logic              timeout_q, timeout_d;
  logic [MatchW-1:0] match_q, match_d;

  logic             sig_edge;
  logic [CNT_W-1:0] meas;
  logic [CNT_W:0]   diff;
  logic [CNT_W:0]   diff_abs;
  logic             agree;

  assign sig_edge = s2_q ^ d_q;
  assign meas     = cnt_q + CNT_W'(1);
  assign diff     = {1'b0, meas} - {1'b0, half_period_q};
  assign diff_abs = diff[CNT_W] ? (~diff + (CNT_W + 1)'(1)) : diff;
  assign agree    = (diff_abs <= TolW);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CNT_W'(1);
    half_period_d = half_period_q;
    n_est_d       = n_est_q;
    meas_valid_d  = 1'b0;
    locked_d      = locked_q;
    timeout_d     = 1'b0;
    match_d       = match_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (sig_edge) begin
          state_d = StArmed;
        end
      end
      StArmed, StTrack: begin
        if (sig_edge) begin
          // An edge coinciding with the timeout count still yields a measurement.
          cnt_d         = '0;
          half_period_d = meas;
          n_est_d       = cnt_q;
          meas_valid_d  = 1'b1;
          state_d       = StTrack;
          if (state_q == StArmed) begin
            match_d = '0;
          end else if (agree) begin
            match_d = (match_q == MatchMax) ? MatchMax : match_q + MatchW'(1);
            if (match_d == MatchMax) begin
              locked_d = 1'b1;
            end
          end else begin
            match_d  = '0;
            locked_d = 1'b0;
          end
        end else if (cnt_q == CntLast) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          state_d   = StIdle;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      d_q           <= 1'b0;
      cnt_q         <= '0;
      half_period_q <= '0;
      n_est_q       <= '0;
      meas_valid_q  <= 1'b0;
      locked_q      <= 1'b0;
      timeout_q     <= 1'b0;
      match_q       <= '0;
    end else begin
      state_q       <= state_d;
      s1_q          <= mon_io.sig_in;
      s2_q          <= s1_q;
      d_q           <= s2_q;
      cnt_q         <= cnt_d;
      half_period_q <= half_period_d;
      n_est_q       <= n_est_d;
      meas_valid_q  <= meas_valid_d;
      locked_q      <= locked_d;
      timeout_q     <= timeout_d;
      match_q       <= match_d;
    end
  end

  assign mon_io.half_period = half_period_q;
  assign mon_io.n_est       = n_est_q;
  assign mon_io.meas_valid  = meas_valid_q;
  assign mon_io.locked      = locked_q;
  assign mon_io.timeout     = timeout_q;

`ifdef CLK_PERIOD_MINMAX_EN
  logic [CNT_W-1:0] hp_min_q, hp_min_d;
  logic [CNT_W-1:0] hp_max_q, hp_max_d;

  // Losing lock restarts the jitter window.
  always_comb begin
    hp_min_d = hp_min_q;
    hp_max_d = hp_max_q;
    if (locked_q && !locked_d) begin
      hp_min_d = '1;
      hp_max_d = '0;
    end else if (meas_valid_d) begin
      if (meas < hp_min_q) hp_min_d = meas;
      if (meas > hp_max_q) hp_max_d = meas;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hp_min_q <= '1;
      hp_max_q <= '0;
    end else begin
      hp_min_q <= hp_min_d;
      hp_max_q <= hp_max_d;
    end
  end

  assign mon_io.hp_min = hp_min_q;
  assign mon_io.hp_max = hp_max_q;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: three instances (TOL=0, TOL=2, TIMEOUT=20) share one input.
// Min/max checks are included when CLK_PERIOD_MINMAX_EN is defined.
module tb_clk_period_meter;

  logic clk;
  logic reset;
  logic sig;
  logic mon_clr;
  int   checks;
  int   failures;

  clk_period_meter_if #(.CNT_W(16)) if_a ();
  clk_period_meter_if #(.CNT_W(16)) if_b ();
  clk_period_meter_if #(.CNT_W(16)) if_c ();

  assign if_a.sig_in = sig;
  assign if_b.sig_in = sig;
  assign if_c.sig_in = sig;

  clk_period_meter #(.CNT_W(16), .LOCK_COUNT(4), .TOL(0), .TIMEOUT(1000)) u_a (
    .clk(clk), .reset(reset), .mon_io(if_a)
  );
  clk_period_meter #(.CNT_W(16), .LOCK_COUNT(4), .TOL(2), .TIMEOUT(1000)) u_b (
    .clk(clk), .reset(reset), .mon_io(if_b)
  );
  clk_period_meter #(.CNT_W(16), .LOCK_COUNT(4), .TOL(0), .TIMEOUT(20)) u_c (
    .clk(clk), .reset(reset), .mon_io(if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        mv_w[3];
  logic        to_w[3];
  logic        lk_w[3];
  logic [15:0] hp_w[3];

  assign mv_w[0] = if_a.meas_valid;
  assign mv_w[1] = if_b.meas_valid;
  assign mv_w[2] = if_c.meas_valid;
  assign to_w[0] = if_a.timeout;
  assign to_w[1] = if_b.timeout;
  assign to_w[2] = if_c.timeout;
  assign lk_w[0] = if_a.locked;
  assign lk_w[1] = if_b.locked;
  assign lk_w[2] = if_c.locked;
  assign hp_w[0] = if_a.half_period;
  assign hp_w[1] = if_b.half_period;
  assign hp_w[2] = if_c.half_period;

  // Event recorder per instance; indices count measurements since the last clear.
  int          cyc;
  int          mv_cnt[3];
  int          to_cnt[3];
  int          rise_first[3];
  int          rise_last[3];
  int          fall_at[3];
  int          fall_cnt[3];
  int          bad_cnt[3];
  int          last_mv_cyc[3];
  int          prev_mv_cyc[3];
  int          to_cyc[3];
  logic [15:0] last_hp[3];
  logic        lk_prev[3];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      lk_prev[i] <= lk_w[i];
      if (mon_clr) begin
        mv_cnt[i]      <= 0;
        to_cnt[i]      <= 0;
        rise_first[i]  <= 0;
        rise_last[i]   <= 0;
        fall_at[i]     <= 0;
        fall_cnt[i]    <= 0;
        bad_cnt[i]     <= 0;
        last_mv_cyc[i] <= 0;
        prev_mv_cyc[i] <= 0;
        to_cyc[i]      <= 0;
        last_hp[i]     <= '0;
      end else begin
        if (mv_w[i]) begin
          mv_cnt[i]      <= mv_cnt[i] + 1;
          last_hp[i]     <= hp_w[i];
          prev_mv_cyc[i] <= last_mv_cyc[i];
          last_mv_cyc[i] <= cyc;
        end
        if (to_w[i]) begin
          to_cnt[i] <= to_cnt[i] + 1;
          to_cyc[i] <= cyc;
        end
        if (lk_w[i] && !lk_prev[i]) begin
          rise_last[i] <= mv_cnt[i] + 1;
          if (rise_first[i] == 0) rise_first[i] <= mv_cnt[i] + 1;
        end
        if (!lk_w[i] && lk_prev[i] && !reset) begin
          fall_cnt[i] <= fall_cnt[i] + 1;
          fall_at[i]  <= mv_cnt[i] + (mv_w[i] ? 1 : 0);
        end
        if (!reset && ((mv_w[i] && to_w[i]) ||
                       ((lk_w[i] != lk_prev[i]) && !mv_w[i] && !to_w[i]))) begin
          bad_cnt[i] <= bad_cnt[i] + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic edges(input int p, input int n);
    repeat (n) begin
      repeat (p) @(posedge clk);
      #1 sig = ~sig;
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sig   = 1'b0;
    settle(2);
    reset = 1'b0;
    clear_mon();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    sig      = 1'b0;
    reset    = 1'b1;
    mon_clr  = 1'b0;
    settle(3);
    check("rst_half_period", int'(if_a.half_period), 0);
    check("rst_n_est", int'(if_a.n_est), 0);
    check("rst_meas_valid", int'(if_a.meas_valid), 0);
    check("rst_locked", int'(if_a.locked), 0);
    check("rst_timeout", int'(if_a.timeout), 0);
`ifdef CLK_PERIOD_MINMAX_EN
    check("rst_hp_min", int'(if_b.hp_min), 65535);
    check("rst_hp_max", int'(if_b.hp_max), 0);
`endif
    reset = 1'b0;
    clear_mon();

    // N=3 stream, one interval of 6, then relock at P=4.
    edges(4, 5);
    edges(6, 1);
    edges(4, 4);
    settle(5);
    check("a_mv_count", mv_cnt[0], 9);
    check("a_half_period", int'(last_hp[0]), 4);
    check("a_n_est", int'(if_a.n_est), 3);
    check("a_mv_spacing", last_mv_cyc[0] - prev_mv_cyc[0], 4);
    check("a_first_lock_meas", rise_first[0], 4);
    check("a_lock_drop_meas", fall_at[0], 5);
    check("a_relock_meas", rise_last[0], 9);
    check("a_locked", int'(if_a.locked), 1);
    check("b_tol2_first_lock", rise_first[1], 4);
    check("b_tol2_no_drop", fall_cnt[1], 0);
    check("b_tol2_locked", int'(if_b.locked), 1);
    check("c_locked_before_los", int'(if_c.locked), 1);

    // Hold input constant: only the TIMEOUT=20 instance loses signal.
    settle(25);
    check("c_timeout_count", to_cnt[2], 1);
    check("c_timeout_delay", to_cyc[2] - last_mv_cyc[2], 20);
    check("c_locked_after_los", int'(if_c.locked), 0);
    check("c_hp_kept", int'(if_c.half_period), 4);
    check("a_no_timeout", to_cnt[0], 0);

    // Resume: first edge only re-arms, second measures.
    edges(4, 2);
    settle(5);
    check("c_resume_mv_count", mv_cnt[2], 10);
    check("c_resume_hp", int'(last_hp[2]), 4);
    check("c_resume_no_timeout", to_cnt[2], 1);

    // N=255 divider.
    do_reset();
    edges(256, 5);
    settle(5);
    check("n255_mv_count", mv_cnt[0], 4);
    check("n255_half_period", int'(last_hp[0]), 256);
    check("n255_n_est", int'(if_a.n_est), 255);
    check("n255_lock_meas", rise_first[0], 4);
    check("n255_locked", int'(if_a.locked), 1);
    check("n255_no_timeout", to_cnt[0], 0);

    // Reset mid-interval while locked.
    do_reset();
    edges(4, 5);
    settle(5);
    check("mid_locked_pre", int'(if_a.locked), 1);
    reset = 1'b1;
    sig   = 1'b0;
    settle(1);
    check("mid_rst_half_period", int'(if_a.half_period), 0);
    check("mid_rst_n_est", int'(if_a.n_est), 0);
    check("mid_rst_locked", int'(if_a.locked), 0);
    check("mid_rst_meas_valid", int'(if_a.meas_valid), 0);
    reset = 1'b0;
    clear_mon();
    edges(4, 2);
    settle(5);
    check("post_rst_mv_count", mv_cnt[0], 1);
    check("post_rst_hp", int'(last_hp[0]), 4);

`ifdef CLK_PERIOD_MINMAX_EN
    do_reset();
    edges(4, 1);
    edges(4, 1);
    edges(5, 1);
    edges(4, 1);
    edges(3, 1);
    settle(5);
    check("minmax_hp_min", int'(if_b.hp_min), 3);
    check("minmax_hp_max", int'(if_b.hp_max), 5);
`endif

    for (int i = 0; i < 3; i++) begin
      check($sformatf("invariants_%0d", i), bad_cnt[i], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
